// File: rtl/ld_ext_pkg.sv
// ld_ext_pkg: shared load-width selects, FSM state encoding and the
// alignment-fault helper used by the load-return unit.
package ld_ext_pkg;

   // Load width select as driven by the MEM stage; 2'b11 decodes as word.
   localparam logic [1:0] LDSEL_W = 2'b00;
   localparam logic [1:0] LDSEL_H = 2'b01;
   localparam logic [1:0] LDSEL_B = 2'b10;

   typedef enum logic [1:0] {
      LDST_IDLE = 2'b00,
      LDST_WAIT = 2'b01,
      LDST_RESP = 2'b10
   } ldst_e;

   // A halfword must sit on an even address, a word on a 4-byte boundary.
   function automatic logic ld_misaligned(input logic [1:0] sel, input logic [1:0] a);
      case (sel)
         LDSEL_H: return a[0];
         LDSEL_B: return 1'b0;
         default: return |a;
      endcase
   endfunction

endpackage

// File: rtl/ld_ext_align.sv
// ld_align: combinational lane logic shared by the request and return paths.
// Produces the bus lane enables for a width/offset and the zero/sign
// extended lane extracted from a read word.
module ld_align
   import ld_ext_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  sel,
   input  logic        sign,
   input  logic [1:0]  a,
   output logic [31:0] data,
   output logic [3:0]  be
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed lane, then extend it according to width and sign.
   always_comb begin
      lane_b = rdata[7:0];
      case (a)
         2'b00: lane_b = rdata[7:0];
         2'b01: lane_b = rdata[15:8];
         2'b10: lane_b = rdata[23:16];
         2'b11: lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = a[1] ? rdata[31:16] : rdata[15:0];
      data   = rdata;
      be     = 4'b1111;
      case (sel)
         LDSEL_B: begin
            data = {{24{sign & lane_b[7]}}, lane_b};
            be   = 4'b0001 << a;
         end
         LDSEL_H: begin
            data = {{16{sign & lane_h[15]}}, lane_h};
            be   = a[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            data = rdata;
            be   = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/ld_ext.sv
// ld_ext: MEM-stage load-return unit. Issues one word-aligned bus read per
// load, waits for ack (bounded by a TIMEOUT_W-bit counter), then returns the
// extended lane with a one-cycle ld_done pulse.
// Optional build macro LDEXT_ALIGN_CHK_EN: misaligned H/W loads skip the bus
// and complete next cycle with ld_adel set.
module ld_ext
   import ld_ext_pkg::*;
#(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [1:0]  ld_sel,
   input  logic        ld_sign,
   input  logic [31:0] ld_addr,
   output logic        ld_busy,
   output logic        ld_done,
   output logic [31:0] ld_data,
   output logic        ld_err,
   output logic        ld_adel,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   ldst_e                state, state_nxt;
   logic [1:0]           sel_q;
   logic                 sign_q;
   logic [1:0]           a_q;
   logic [TIMEOUT_W-1:0] cnt, cnt_inc;
   logic                 expire;
   logic                 misal;

   logic [1:0]           al_sel;
   logic                 al_sign;
   logic [1:0]           al_a;
   logic [31:0]          al_data;
   logic [3:0]           al_be;

`ifdef LDEXT_ALIGN_CHK_EN
   assign misal = ld_misaligned(ld_sel, ld_addr[1:0]);
`else
   assign misal = 1'b0;
`endif

   // The ack-wait window closes when the incremented count hits all-ones,
   // giving 2^TIMEOUT_W-1 cycles of bus_req before the abort.
   assign cnt_inc = cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   assign expire  = &cnt_inc;

   // One lane unit serves both paths: live request fields in IDLE produce
   // the lane enables, latched fields afterwards extract the read data.
   always_comb begin
      al_sel  = sel_q;
      al_sign = sign_q;
      al_a    = a_q;
      if (state == LDST_IDLE) begin
         al_sel  = ld_sel;
         al_sign = ld_sign;
         al_a    = ld_addr[1:0];
      end
   end

   ld_align u_align (
      .rdata (bus_rdata),
      .sel   (al_sel),
      .sign  (al_sign),
      .a     (al_a),
      .data  (al_data),
      .be    (al_be)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= LDST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and the combinational handshake outputs.
   always_comb begin
      state_nxt = state;
      ld_busy   = 1'b0;
      bus_req   = 1'b0;
      ld_done   = 1'b0;
      case (state)
         LDST_IDLE: begin
            if (ld_valid) begin
               ld_busy   = 1'b1;
               state_nxt = misal ? LDST_RESP : LDST_WAIT;
            end
         end
         LDST_WAIT: begin
            ld_busy = 1'b1;
            bus_req = 1'b1;
            if (bus_ack || expire) state_nxt = LDST_RESP;
         end
         LDST_RESP: begin
            // ld_valid is still the completed request here, so it is ignored.
            ld_done   = 1'b1;
            state_nxt = LDST_IDLE;
         end
         default: state_nxt = LDST_IDLE;
      endcase
   end

   // Request latch, bus address/enables, wait counter and the result regs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q    <= LDSEL_W;
         sign_q   <= 1'b0;
         a_q      <= 2'b00;
         cnt      <= '0;
         bus_addr <= 32'h0;
         bus_be   <= 4'h0;
         ld_data  <= 32'h0;
         ld_err   <= 1'b0;
         ld_adel  <= 1'b0;
      end else begin
         case (state)
            LDST_IDLE: begin
               if (ld_valid) begin
                  sel_q    <= ld_sel;
                  sign_q   <= ld_sign;
                  a_q      <= ld_addr[1:0];
                  cnt      <= '0;
                  bus_addr <= {ld_addr[31:2], 2'b00};
                  bus_be   <= misal ? 4'h0 : al_be;
                  ld_data  <= 32'h0;
                  ld_err   <= 1'b0;
                  ld_adel  <= misal;
               end
            end
            LDST_WAIT: begin
               cnt <= cnt_inc;
               // An ack landing in the expiry cycle still delivers data.
               if (bus_ack) begin
                  ld_data <= al_data;
                  ld_err  <= 1'b0;
               end else if (expire) begin
                  ld_data <= 32'h0;
                  ld_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ld_ext.sv
// tb_ld_ext: table-driven and randomised loads against the load-return unit,
// with a scoreboard of expected completions checked on every ld_done.
module tb_ld_ext;
   import ld_ext_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic [1:0]  ld_sel;
   logic        ld_sign;
   logic [31:0] ld_addr;
   logic        ld_busy, ld_done, ld_err, ld_adel, bus_req;
   logic [31:0] ld_data, bus_addr;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        adel;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [1:0]  sel;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          k;
      logic [3:0]  be;
      logic [31:0] data;
   } vec_t;
   vec_t vecs[8];

   ld_ext #(.TIMEOUT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_sel    (ld_sel),
      .ld_sign   (ld_sign),
      .ld_addr   (ld_addr),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .ld_data   (ld_data),
      .ld_err    (ld_err),
      .ld_adel   (ld_adel),
      .bus_req   (bus_req),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference lane model written independently of the RTL structure.
   function automatic logic [31:0] model(input logic [1:0] sel, input logic sign,
                                         input logic [1:0] a, input logic [31:0] rd);
      logic [31:0] sh;
      case (sel)
         LDSEL_B: begin
            sh = rd >> (8 * a);
            return sign ? 32'(signed'(sh[7:0])) : 32'(sh[7:0]);
         end
         LDSEL_H: begin
            sh = rd >> (16 * a[1]);
            return sign ? 32'(signed'(sh[15:0])) : 32'(sh[15:0]);
         end
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sel, input logic [1:0] a);
      case (sel)
         LDSEL_B: return 4'b0001 << a;
         LDSEL_H: return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Completion monitor: every ld_done must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && ld_done) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'(ld_done), 32'h0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("ld_data", ld_data, e.data);
            chk("ld_err", 32'(ld_err), 32'(e.err));
            chk("ld_adel", 32'(ld_adel), 32'(e.adel));
         end
      end
   end

   // Issue one load (called #1 after a rising edge), ack it in cycle k.
   task automatic run_load(input logic [1:0] sel, input logic sign, input logic [31:0] addr,
                           input logic [31:0] rd, input int k, input logic [3:0] be,
                           input logic [31:0] data);
      exp_t e;
      ld_valid = 1'b1;
      ld_sel   = sel;
      ld_sign  = sign;
      ld_addr  = addr;
      e.data = data; e.err = 1'b0; e.adel = 1'b0; e.cyc = cyc + k + 1;
      sbq.push_back(e);
      @(negedge clk);
      chk("busy_c0", 32'(ld_busy), 32'h1);
      chk("req_c0", 32'(bus_req), 32'h0);
      for (int c = 1; c <= k; c++) begin
         @(posedge clk); #1;
         bus_ack   = (c == k);
         bus_rdata = (c == k) ? rd : $urandom;
         @(negedge clk);
         chk("req_wait", 32'(bus_req), 32'h1);
         chk("busy_wait", 32'(ld_busy), 32'h1);
         chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
         chk("bus_be", 32'(bus_be), 32'(be));
      end
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      @(negedge clk);
      chk("busy_resp", 32'(ld_busy), 32'h0);
      chk("req_resp", 32'(bus_req), 32'h0);
      chk("addr_resp", bus_addr, {addr[31:2], 2'b00});
      chk("be_resp", 32'(bus_be), 32'(be));
      @(posedge clk); #1;
      ld_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;
      logic [1:0]  rs, ra;
      logic [31:0] rrd;

      vecs[0] = '{LDSEL_B, 1'b1, 32'h0000_0101, 32'h1234_80FF, 1, 4'b0010, 32'hFFFF_FF80};
      vecs[1] = '{LDSEL_H, 1'b0, 32'h0000_0202, 32'hBEEF_0000, 5, 4'b1100, 32'h0000_BEEF};
      vecs[2] = '{LDSEL_W, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 2, 4'b1111, 32'hDEAD_BEEF};
      vecs[3] = '{LDSEL_B, 1'b0, 32'h0000_0303, 32'h8000_0000, 1, 4'b1000, 32'h0000_0080};
      vecs[4] = '{LDSEL_H, 1'b1, 32'h0000_0400, 32'h0000_8001, 3, 4'b0011, 32'hFFFF_8001};
      vecs[5] = '{LDSEL_B, 1'b1, 32'h0000_0502, 32'h007F_0000, 1, 4'b0100, 32'h0000_007F};
      vecs[6] = '{2'b11,   1'b1, 32'h0000_0608, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D};
      // Ack in the expiry cycle (7th wait cycle with TIMEOUT_W=3): ack wins.
      vecs[7] = '{LDSEL_H, 1'b1, 32'h0000_0702, 32'h7FFF_1234, 7, 4'b1100, 32'h0000_7FFF};

      rst = 1'b1; ld_valid = 1'b0; ld_sel = LDSEL_W; ld_sign = 1'b0; ld_addr = 32'h0;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(bus_req), 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_be", 32'(bus_be), 32'h0);
      chk("rst_done", 32'(ld_done), 32'h0);
      chk("rst_data", ld_data, 32'h0);
      chk("rst_err_adel", {30'h0, ld_err, ld_adel}, 32'h0);
      chk("rst_busy", 32'(ld_busy), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table, issued back to back.
      for (int i = 0; i < 8; i++)
         run_load(vecs[i].sel, vecs[i].sign, vecs[i].addr, vecs[i].rdata,
                  vecs[i].k, vecs[i].be, vecs[i].data);

      // Bus timeout: no ack, bus_req held for 7 cycles then ld_err.
      ld_valid = 1'b1; ld_sel = LDSEL_W; ld_sign = 1'b0; ld_addr = 32'h0000_0040;
      e.data = 32'h0; e.err = 1'b1; e.adel = 1'b0; e.cyc = cyc + 8;
      sbq.push_back(e);
      n = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus_req) break;
         n++;
         bus_rdata = $urandom;
         @(posedge clk); #1;
      end
      chk("timeout_req_cycles", 32'(n), 32'd7);
      @(posedge clk); #1;
      ld_valid = 1'b0;

      // Reset while waiting, then a late ack: nothing completes.
      ld_valid = 1'b1; ld_sel = LDSEL_W; ld_addr = 32'h0000_0020;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; ld_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("wrst_req", 32'(bus_req), 32'h0);
      chk("wrst_addr_be", bus_addr | 32'(bus_be), 32'h0);
      chk("wrst_busy", 32'(ld_busy), 32'h0);
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("wrst_late_done", 32'(ld_done), 32'h0);
      chk("wrst_data", ld_data, 32'h0);
      chk("wrst_err", 32'(ld_err), 32'h0);
      @(posedge clk); #1;

      // Misaligned halfword.
`ifdef LDEXT_ALIGN_CHK_EN
      ld_valid = 1'b1; ld_sel = LDSEL_H; ld_sign = 1'b0; ld_addr = 32'h0000_0101;
      e.data = 32'h0; e.err = 1'b0; e.adel = 1'b1; e.cyc = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      chk("mis_busy", 32'(ld_busy), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_req", 32'(bus_req), 32'h0);
      @(posedge clk); #1;
      ld_valid = 1'b0;
`else
      run_load(LDSEL_H, 1'b0, 32'h0000_0101, 32'h1234_ABCD, 2, 4'b0011, 32'h0000_ABCD);
`endif

      // Randomised aligned loads checked against the lane model.
      for (int i = 0; i < 8; i++) begin
         rs  = 2'($urandom_range(0, 3));
         ra  = 2'($urandom_range(0, 3));
         if (rs == LDSEL_H) ra[0] = 1'b0;
         if (rs == LDSEL_W || rs == 2'b11) ra = 2'b00;
         rrd = $urandom;
         n   = $urandom & 1;
         run_load(rs, n[0], {20'h0, 10'(i), ra}, rrd, $urandom_range(1, 6),
                  model_be(rs, ra), model(rs, n[0], ra, rrd));
      end

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
